// File: rtl/reg_readout_pkg.sv
// Shared definitions for the register readout serializer: FSM encoding and default sizing.
package reg_readout_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam int unsigned DefaultN   = 8;
  localparam int unsigned DefaultDiv = 4;

endpackage

// File: rtl/piso_shift.sv
// N-bit parallel-load register that shifts left (zero fill); MSB is the serial output.
module piso_shift #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         msb
);

  logic [N-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[N-2:0], 1'b0};
    end
  end

  assign msb = sr_q[N-1];

endmodule

// File: rtl/reg_readout.sv
// Captures one of four registers and streams it MSB first, each bit held DIV cycles,
// followed by a one-cycle done marker.
module reg_readout
  import reg_readout_pkg::*;
#(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned DIV = DefaultDiv
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   sel,
  input  logic [N-1:0] r0,
  input  logic [N-1:0] r1,
  input  logic [N-1:0] r2,
  input  logic [N-1:0] r3,
  output logic         sdo,
  output logic         sval,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(N + 1);

  state_e          state_q;
  logic [DivW-1:0] div_q;
  logic [BitW-1:0] bit_q;
  logic            sval_q;
  logic            busy_q;
  logic            done_q;

  logic            div_end;
  logic            capture;
  logic            shift_en;
  logic            msb;
  logic [N-1:0]    sel_val;

  always_comb begin
    sel_val = r0;
    unique case (sel)
      2'd0: sel_val = r0;
      2'd1: sel_val = r1;
      2'd2: sel_val = r2;
      2'd3: sel_val = r3;
      default: sel_val = r0;
    endcase
  end

  assign div_end  = (div_q == DivW'(DIV - 1));
  assign capture  = (state_q == StIdle) && start;
  assign shift_en = (state_q == StShift) && div_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShift;
            div_q   <= '0;
            bit_q   <= '0;
            sval_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (div_end) begin
            div_q <= '0;
            bit_q <= bit_q + 1'b1;
            // Last bit period ends: leave SHIFT for the single done cycle.
            if (bit_q == BitW'(N - 1)) begin
              state_q <= StDone;
              sval_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          sval_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  piso_shift #(
    .N(N)
  ) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (capture),
    .shift(shift_en),
    .din  (sel_val),
    .msb  (msb)
  );

  assign sdo  = sval_q & msb;
  assign sval = sval_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/reg_readout.md
REG_READOUT -- requirements
Module: reg_readout

Interface
REQ-001 Parameter N, default 8: width of each source register and of the serial frame.
REQ-002 Parameter DIV, default 4: clock cycles per serial bit; legal range 1..256.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  request to read out the selected register; level-sampled.
REQ-006 sel  input  2  source select: 0=r0, 1=r1, 2=r2, 3=r3.
REQ-007 r0, r1, r2, r3  input  N each  parallel register values to be read.
REQ-008 sdo  output  1  serial data out, MSB first.
REQ-009 sval  output  1  high while sdo carries a valid frame bit.
REQ-010 busy  output  1  high from capture until the end of the frame; start is ignored while high.
REQ-011 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and DONE; there are no other reachable states.
REQ-013 In IDLE with start=1 at posedge k, the block SHALL capture the sel-chosen register into an N-bit shift register, clear the bit and divide counters, and enter SHIFT.
REQ-014 In SHIFT, sdo SHALL equal the shift register MSB and sval SHALL be 1; each bit SHALL be held for exactly DIV cycles.
REQ-015 After each DIV-cycle bit period, the shift register SHALL shift left one place (LSB fill 0) and the bit counter SHALL increment.
REQ-016 When the bit counter reaches N at the end of a bit period, the block SHALL enter DONE; bit N-1 SHALL be the last bit presented.
REQ-017 In DONE, done SHALL be 1, busy SHALL be 1, sval SHALL be 0 and sdo SHALL be 0 for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Timing: for start sampled at edge k, sval SHALL be high in cycles k+1 .. k+N*DIV, and done SHALL be high in cycle k+N*DIV+1.
REQ-019 Busy SHALL be high in SHIFT and DONE only, for N*DIV+1 cycles in total.
REQ-020 Start asserted while busy=1 SHALL be ignored and not queued.
REQ-021 Start held continuously SHALL begin a new frame on the first IDLE cycle after DONE, giving back-to-back frames with a single IDLE gap.
REQ-022 Changes to r0..r3 or sel after capture SHALL NOT affect the frame in progress.
REQ-023 With DIV=1, one bit SHALL be emitted per cycle with no stretching.
REQ-024 Counter widths SHALL be sized from N and DIV with no wrap before the terminal count.

Reset
REQ-025 reset=1 at any edge SHALL force IDLE and clear the shift register and counters, including mid-frame.
REQ-026 Outputs after a reset edge SHALL be: sdo=0, sval=0, busy=0, done=0.
REQ-027 Start coincident with reset SHALL be ignored; reset has priority.
REQ-028 An aborted frame SHALL NOT produce a done pulse.

Structure
REQ-029 A shared package SHALL hold the state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default N and DIV constants.
REQ-030 The N-bit parallel-load, shift-left register SHALL be a separate sub-module, piso_shift.
REQ-031 The FSM, bit counter and divide counter SHALL live in reg_readout.

Verification
REQ-032 With N=8, DIV=1, r2=8'hA5, sel=2, and a start pulse: sdo SHALL be 1,0,1,0,0,1,0,1 over 8 cycles with sval=1, then done=1 for one cycle.
REQ-033 With N=8, DIV=4, r0=8'h81: sdo SHALL be high for 4 cycles, low for 24 cycles, then high for 4 cycles, with busy high for 33 cycles.
REQ-034 After capturing r1=8'hFF, change r1 to 8'h00 and pulse start again mid-frame: the frame SHALL still be all ones, with no second frame and one done pulse.
REQ-035 Assert reset at cycle 3 of a frame: the next cycle SHALL show sdo=0, sval=0, busy=0, with no done pulse; a following start SHALL produce a complete correct frame.
REQ-036 Hold start high with sel=3 and r3=8'h3C: the bench SHALL see two identical frames separated by the DONE cycle plus one IDLE cycle.
